// File: rtl/route_compute_stage_pkg.sv
// Shared field layout, direction indices and helpers for the route-compute stage
// and the port allocator that consumes its request vectors.
package route_compute_stage_pkg;
  localparam int X_W      = 3;
  localparam int Y_W      = 3;
  localparam int NODE_W   = 6;
  localparam int AGE_W    = 8;
  localparam int DATA_W   = 32;

  // Flit layout, LSB first: dst_x, dst_y, src_id, age, data
  localparam int DST_X_LSB = 0;
  localparam int DST_Y_LSB = DST_X_LSB + X_W;
  localparam int SRC_LSB   = DST_Y_LSB + Y_W;
  localparam int AGE_LSB   = SRC_LSB + NODE_W;
  localparam int DATA_LSB  = AGE_LSB + AGE_W;
  localparam int FLIT_W    = DATA_LSB + DATA_W;

  localparam int WIDTH_PV = 4;
  localparam int DIR_N    = 3;
  localparam int DIR_E    = 2;
  localparam int DIR_S    = 1;
  localparam int DIR_W    = 0;

  typedef struct packed {
    logic [WIDTH_PV-1:0] req;
    logic                eject;
    logic                golden;
  } route_res_t;

  function automatic logic [AGE_W-1:0] age_inc(input logic [AGE_W-1:0] a);
    return (a == '1) ? a : a + 1'b1;
  endfunction
endpackage

// File: rtl/route_compute_stage_route_calc.sv
// Per-channel combinational route computation: productive directions, eject,
// golden flag and the aged copy of the flit.
module route_calc
  import route_compute_stage_pkg::*;
(
  input  logic              valid_i,
  input  logic [FLIT_W-1:0] flit_i,
  input  logic [X_W-1:0]    local_x_i,
  input  logic [Y_W-1:0]    local_y_i,
  input  logic [NODE_W-1:0] golden_id_i,
  output route_res_t        res_o,
  output logic [FLIT_W-1:0] flit_o
);
  logic [X_W-1:0]    dst_x;
  logic [Y_W-1:0]    dst_y;
  logic [NODE_W-1:0] src_id;
  logic [AGE_W-1:0]  age;

  assign dst_x  = flit_i[DST_X_LSB +: X_W];
  assign dst_y  = flit_i[DST_Y_LSB +: Y_W];
  assign src_id = flit_i[SRC_LSB +: NODE_W];
  assign age    = flit_i[AGE_LSB +: AGE_W];

  always_comb begin
    res_o  = '0;
    flit_o = flit_i;
    flit_o[AGE_LSB +: AGE_W] = age_inc(age);
    if (valid_i) begin
      // a flit at its destination compares equal on both axes, so req stays 0
      res_o.req[DIR_N] = dst_y > local_y_i;
      res_o.req[DIR_S] = dst_y < local_y_i;
      res_o.req[DIR_E] = dst_x > local_x_i;
      res_o.req[DIR_W] = dst_x < local_x_i;
      res_o.eject      = (dst_x == local_x_i) && (dst_y == local_y_i);
      res_o.golden     = src_id == golden_id_i;
    end
  end
endmodule

// File: rtl/route_compute_stage.sv
// Route-compute stage: one-cycle registered pass of NUM_CH link flits with
// request/eject/golden annotation and a rotating golden-source epoch counter.
module route_compute_stage
  import route_compute_stage_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int NUM_NODES    = 64,
  parameter int GOLDEN_EPOCH = 64
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [X_W-1:0]               local_x,
  input  logic [Y_W-1:0]               local_y,
  input  logic [NUM_CH-1:0]            in_valid,
  input  logic [NUM_CH*FLIT_W-1:0]     in_flit,
  output logic [NUM_CH-1:0]            out_valid,
  output logic [NUM_CH*FLIT_W-1:0]     out_flit,
  output logic [NUM_CH*WIDTH_PV-1:0]   out_req,
  output logic [NUM_CH-1:0]            out_eject,
  output logic [NUM_CH-1:0]            out_golden
);
  localparam int EP_W = (GOLDEN_EPOCH > 1) ? $clog2(GOLDEN_EPOCH) : 1;

  logic [EP_W-1:0]   epoch_q, epoch_d;
  logic [NODE_W-1:0] golden_q, golden_d;

  route_res_t                 res [NUM_CH];
  logic [NUM_CH*FLIT_W-1:0]   flit_d;
  logic [NUM_CH*WIDTH_PV-1:0] req_d;
  logic [NUM_CH-1:0]          eject_d, golden_d_v;

  logic [NUM_CH-1:0]          valid_q, eject_q, golden_v_q;
  logic [NUM_CH*FLIT_W-1:0]   flit_q;
  logic [NUM_CH*WIDTH_PV-1:0] req_q;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    route_calc u_rc (
      .valid_i    (in_valid[c]),
      .flit_i     (in_flit[c*FLIT_W +: FLIT_W]),
      .local_x_i  (local_x),
      .local_y_i  (local_y),
      .golden_id_i(golden_q),
      .res_o      (res[c]),
      .flit_o     (flit_d[c*FLIT_W +: FLIT_W])
    );
    assign req_d[c*WIDTH_PV +: WIDTH_PV] = res[c].req;
    assign eject_d[c]    = res[c].eject;
    assign golden_d_v[c] = res[c].golden;
  end

  // golden_q seen by the route_calc instances is the pre-increment id, so a
  // capture coinciding with the epoch wrap still uses the old source
  always_comb begin
    epoch_d  = epoch_q + 1'b1;
    golden_d = golden_q;
    if (epoch_q == EP_W'(GOLDEN_EPOCH - 1)) begin
      epoch_d  = '0;
      golden_d = (golden_q == NODE_W'(NUM_NODES - 1)) ? '0 : golden_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      epoch_q    <= '0;
      golden_q   <= '0;
      valid_q    <= '0;
      flit_q     <= '0;
      req_q      <= '0;
      eject_q    <= '0;
      golden_v_q <= '0;
    end else begin
      epoch_q    <= epoch_d;
      golden_q   <= golden_d;
      valid_q    <= in_valid;
      flit_q     <= flit_d;
      req_q      <= req_d;
      eject_q    <= eject_d;
      golden_v_q <= golden_d_v;
    end
  end

  assign out_valid  = valid_q;
  assign out_flit   = flit_q;
  assign out_req    = req_q;
  assign out_eject  = eject_q;
  assign out_golden = golden_v_q;
endmodule

// File: tb/tb_route_compute_stage.sv
// Randomized bench for route_compute_stage with a cycle-indexed reference model
// and directed literal checks of the documented scenarios.
module tb_route_compute_stage;
  localparam int NCH = 4;
  localparam int FW  = 52;
  localparam int PV  = 4;
  localparam int EP  = 4;
  localparam int NN  = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic [2:0]      local_x, local_y;
  logic [NCH-1:0]  in_valid;
  logic [NCH*FW-1:0] in_flit;
  logic [NCH-1:0]  out_valid;
  logic [NCH*FW-1:0] out_flit;
  logic [NCH*PV-1:0] out_req;
  logic [NCH-1:0]  out_eject, out_golden;

  int n_cmp = 0;
  int n_err = 0;

  route_compute_stage #(.NUM_CH(NCH), .NUM_NODES(NN), .GOLDEN_EPOCH(EP)) dut (
    .clk(clk), .reset(reset), .local_x(local_x), .local_y(local_y),
    .in_valid(in_valid), .in_flit(in_flit), .out_valid(out_valid),
    .out_flit(out_flit), .out_req(out_req), .out_eject(out_eject),
    .out_golden(out_golden)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [FW-1:0] mk(input int dx, input int dy, input int src,
                                       input int age, input logic [31:0] data);
    logic [2:0] x; logic [2:0] y; logic [5:0] s; logic [7:0] a;
    x = 3'(dx); y = 3'(dy); s = 6'(src); a = 8'(age);
    return {data, a, s, y, x};
  endfunction

  // Reference model: golden id is a pure function of the capture index since reset
  int cap = 0;
  always begin
    logic [NCH-1:0]    ev, ee, eg;
    logic [NCH*FW-1:0] ef, fm;
    logic [NCH*PV-1:0] er;
    logic [FW-1:0]     f;
    int gid, dx, dy, ag;
    @(posedge clk);
    ev = '0; ee = '0; eg = '0; ef = '0; er = '0; fm = '1;
    if (reset) begin
      cap = 0;
    end else begin
      gid = (cap / EP) % NN;
      for (int c = 0; c < NCH; c++) begin
        f  = in_flit[c*FW +: FW];
        ag = int'(f[19:12]);
        f[19:12] = 8'((ag == 255) ? 255 : ag + 1);
        ef[c*FW +: FW] = f;
        if (!in_valid[c]) fm[c*FW +: FW] = '0;
        if (in_valid[c]) begin
          dx = int'(f[2:0]); dy = int'(f[5:3]);
          ev[c] = 1'b1;
          if (dx == int'(local_x) && dy == int'(local_y)) ee[c] = 1'b1;
          er[c*PV+3] = dy > int'(local_y);
          er[c*PV+2] = dx > int'(local_x);
          er[c*PV+1] = dy < int'(local_y);
          er[c*PV+0] = dx < int'(local_x);
          eg[c] = int'(f[11:6]) == gid;
        end
      end
      cap++;
    end
    #1;
    check("valid",  256'(out_valid), 256'(ev));
    check("flit",   256'(out_flit & fm), 256'(ef & fm));
    check("req",    256'(out_req), 256'(er));
    check("eject",  256'(out_eject), 256'(ee));
    check("golden", 256'(out_golden), 256'(eg));
  end

  task automatic step();
    @(posedge clk); #2;
  endtask

  initial begin
    logic [NCH*FW-1:0] fl;
    reset = 1'b1; local_x = 3'd3; local_y = 3'd3; in_valid = '1;
    for (int c = 0; c < NCH; c++) fl[c*FW +: FW] = mk(c, 7 - c, 0, 5, 32'(c));
    in_flit = fl;
    step(); step();
    check("reset_valid", 256'(out_valid), 256'(0));
    check("reset_req",   256'(out_req), 256'(0));

    // golden epoch: src 1 is golden only on captures 4..7
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < NCH; c++) fl[c*FW +: FW] = mk(0, 0, 1, 0, 32'h0);
    in_flit = fl;
    for (int k = 0; k < 20; k++) begin
      step();
      check($sformatf("golden_k%0d", k), 256'(out_golden),
            256'((k >= 4 && k <= 7) ? 4'hF : 4'h0));
      @(negedge clk);
    end

    // N channel, local (3,3), dst (5,1), age 7
    local_x = 3'd3; local_y = 3'd3; in_valid = 4'b1000;
    fl = '0; fl[3*FW +: FW] = mk(5, 1, 9, 7, 32'hCAFE); in_flit = fl;
    step();
    check("t2_req",   256'(out_req[15:12]), 256'(4'b0110));
    check("t2_eject", 256'(out_eject[3]), 256'(0));
    check("t2_age",   256'(out_flit[3*FW+12 +: 8]), 256'(8));

    // W channel ejects at local (2,4); second flit saturates its age
    @(negedge clk);
    local_x = 3'd2; local_y = 3'd4; in_valid = 4'b0011;
    fl = '0; fl[0 +: FW] = mk(2, 4, 0, 3, 32'h1);
    fl[FW +: FW] = mk(0, 0, 0, 255, 32'h2); in_flit = fl;
    step();
    check("t3_req",   256'(out_req[3:0]), 256'(0));
    check("t3_eject", 256'(out_eject[0]), 256'(1));
    check("t4_age",   256'(out_flit[FW+12 +: 8]), 256'(8'hFF));

    // only N and S valid
    @(negedge clk);
    in_valid = 4'b1010;
    for (int c = 0; c < NCH; c++) fl[c*FW +: FW] = mk(7, 0, 2, 1, 32'(c));
    in_flit = fl;
    step();
    check("t6_valid",  256'(out_valid), 256'(4'b1010));
    check("t6_req_ew", 256'({out_req[11:8], out_req[3:0]}), 256'(0));
    check("t6_flags",  256'({out_eject[2], out_eject[0], out_golden[2], out_golden[0]}), 256'(0));

    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 63) == 0);
      if (i % 25 == 0) begin
        local_x = 3'($urandom_range(0, 7)); local_y = 3'($urandom_range(0, 7));
      end
      in_valid = 4'($urandom_range(0, 15));
      for (int c = 0; c < NCH; c++)
        fl[c*FW +: FW] = mk($urandom_range(0, 7), $urandom_range(0, 7),
                            $urandom_range(0, 5),
                            ($urandom_range(0, 7) == 0) ? 255 : $urandom_range(0, 254),
                            $urandom);
      in_flit = fl;
    end
    @(negedge clk);
    reset = 1'b0;
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
